// File: rtl/sync_divider_nx.sv
// Unsigned restoring divider: one quotient bit per clock,
// registered quotient/remainder with a single-cycle done pulse.
module sync_divider_nx #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         res,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    r_q, r_d;
  logic [N-1:0]  w_q, w_d;
  logic [N-1:0]  dv_q, dv_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dz_q, dz_d;

  // One restoring step; R carries an extra bit so the shifted value
  // (always < 2*D) never overflows the compare.
  logic [N:0]   shl_r;
  logic [N:0]   dv_ext;
  logic [N:0]   diff_r;
  logic         fits;
  logic [N:0]   step_r;
  logic [N-1:0] step_w;

  always_comb begin
    shl_r  = {r_q[N-1:0], w_q[N-1]};
    dv_ext = {1'b0, dv_q};
    diff_r = shl_r - dv_ext;
    fits   = (shl_r >= dv_ext);
    step_r = fits ? diff_r : shl_r;
    step_w = {w_q[N-2:0], fits};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    w_d     = w_q;
    dv_d    = dv_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            r_d     = '0;
            w_d     = dividend;
            dv_d    = divisor;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = RUN;
          end else begin
            quo_d  = '1;
            rem_d  = dividend;
            dz_d   = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        r_d   = step_r;
        w_d   = step_w;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          quo_d   = step_w;
          rem_d   = step_r[N-1:0];
          dz_d    = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      w_q     <= '0;
      dv_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      w_q     <= w_d;
      dv_q    <= dv_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_sync_divider_nx.sv
// Randomized and exhaustive checks of sync_divider_nx
// against an arithmetic reference model.
module tb_sync_divider_nx;

  localparam int N = 4;
  localparam int MAXV = (1 << N) - 1;

  logic         clk;
  logic         res;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_zero;

  int checks;
  int errors;

  sync_divider_nx #(.N(N)) dut (
    .clk      (clk),
    .res      (res),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_q(input int a, input int b);
    return (b == 0) ? MAXV : a / b;
  endfunction

  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  // Called at a negedge; issues one start and waits for its done.
  // Leaves the bench at the negedge where done was seen.
  task automatic do_div(input int a, input int b, input string tag);
    int lat;
    int exp_lat;
    dividend = N'(a);
    divisor  = N'(b);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
    lat      = 0;
    while (!done && lat < 3 * N) begin
      chk({tag, "_busy"}, busy, (b != 0));
      @(negedge clk);
      dividend = N'($urandom);
      divisor  = N'($urandom);
      lat++;
    end
    exp_lat = (b == 0) ? 0 : N;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_q"}, quotient, ref_q(a, b));
    chk({tag, "_r"}, remainder, ref_r(a, b));
    chk({tag, "_dz"}, div_zero, (b == 0));
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    int lat;
    int ndone;
    checks   = 0;
    errors   = 0;
    res      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    // reset
    repeat (2) @(negedge clk);
    res = 1'b0;
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_zero, 0);
    @(negedge clk);
    chk("rst_idle_done", done, 0);

    // 13/3 and hold
    do_div(13, 3, "d13_3");
    @(negedge clk);
    chk("hold_done", done, 0);
    chk("hold_q", quotient, 4);
    chk("hold_r", remainder, 1);

    // divide by zero
    do_div(9, 0, "d9_0");
    @(negedge clk);
    chk("dz_pulse", done, 0);
    chk("dz_hold", div_zero, 1);
    chk("dz_nobusy", busy, 0);

    // start while busy is ignored
    dividend = 4'd14;
    divisor  = 4'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 4'd2;
    divisor  = 4'd1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 2;
    while (!done && lat < 3 * N) begin
      dividend = N'($urandom);
      divisor  = N'($urandom);
      @(negedge clk);
      lat++;
    end
    chk("ign_lat", lat, N);
    chk("ign_q", quotient, 4);
    chk("ign_r", remainder, 2);
    ndone = 0;
    repeat (N + 2) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ign_nodup", ndone, 0);

    // reset mid-run
    dividend = 4'd14;
    divisor  = 4'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_done", done, 0);
    ndone = 0;
    repeat (N + 3) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_nodone", ndone, 0);

    // random operands with random idle gaps
    for (int i = 0; i < 40; i++) begin
      int a;
      int b;
      a = int'($urandom_range(0, MAXV));
      b = int'($urandom_range(0, MAXV));
      if ($urandom_range(0, 5) == 0) b = 0;
      do_div(a, b, "rnd");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // back-to-back exhaustive sweep
    for (int a = 0; a <= MAXV; a++) begin
      for (int b = 0; b <= MAXV; b++) begin
        do_div(a, b, "sweep");
      end
    end
    @(negedge clk);
    chk("sweep_tail_done", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
